// File: rtl/frame_buffer_pingpong_if.sv
// Pixel-stream, read-port and swap-control bundle for frame_buffer_pingpong.
// master = producer/display side, slave = the frame store itself.
interface frame_buffer_pingpong_if #(
  parameter int PW = 12,
  parameter int AW = 17
);
  logic          piul1WValid;
  logic          poul1WReady;
  logic          piul1WSof;
  logic [PW-1:0] piulWData;
  logic          piul1REnable;
  logic [AW-1:0] piulRAddr;
  logic [PW-1:0] poulRData;
  logic          poul1RValid;
  logic          piul1SwapReq;
  logic          poul1FrameValid;
  logic          poul1SwapDone;
  logic          poul1SofErr;

  modport master (
    output piul1WValid, piul1WSof, piulWData, piul1REnable, piulRAddr, piul1SwapReq,
    input  poul1WReady, poulRData, poul1RValid, poul1FrameValid, poul1SwapDone, poul1SofErr
  );

  modport slave (
    input  piul1WValid, piul1WSof, piulWData, piul1REnable, piulRAddr, piul1SwapReq,
    output poul1WReady, poulRData, poul1RValid, poul1FrameValid, poul1SwapDone, poul1SofErr
  );
endinterface

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered (ping-pong) frame store.
// The writer fills the back bank from a valid/ready pixel stream; the reader
// fetches random pixels from the front bank with one cycle of latency.
// Banks swap only when the back bank is complete and the reader asks.
// Optional macro FB_OVERWRITE_EN: the writer is never stalled; a new SOF
// while a completed frame waits for its swap discards that frame.
module frame_buffer_pingpong #(
  parameter int P_WIDTH    = 320,
  parameter int P_HEIGHT   = 240,
  parameter int P_CHANNELS = 3,
  parameter int P_BPC      = 4
) (
  input  logic                    piul1Clock,
  input  logic                    piul1Reset_n,
  frame_buffer_pingpong_if.slave  bus
);
  localparam int PW   = P_CHANNELS * P_BPC;
  localparam int NPIX = P_WIDTH * P_HEIGHT;
  localparam int AW   = $clog2(NPIX);
  // Physical address is {bank, pixel}, so each bank spans a power-of-two range.
  localparam int DEPTH = 2 ** (AW + 1);
  localparam logic [AW-1:0] LAST   = AW'(NPIX - 1);
  localparam logic [AW-1:0] ONE    = AW'(1);
  localparam logic [AW:0]   NPIX_W = (AW + 1)'(NPIX);

  typedef enum logic [1:0] {SYNC, FILL, FULL} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          front_reg, front_next;
  logic          frame_valid_reg, frame_valid_next;
  logic          swap_done_reg, swap_done_next;
  logic          sof_err_reg, sof_err_next;
  logic          ready;
  logic          accept;
  logic          wr_en;
  logic [AW-1:0] wr_pix;
  logic [PW-1:0] rdata_reg;
  logic          rvalid_reg;

  logic [PW-1:0] mem [0:DEPTH-1];

`ifdef FB_OVERWRITE_EN
  assign ready = 1'b1;
`else
  assign ready = (state_reg != FULL);
`endif

  assign accept = bus.piul1WValid && ready;

  // Control state, write counter, bank select and registered status pulses.
  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      state_reg       <= SYNC;
      cnt_reg         <= '0;
      front_reg       <= 1'b0;
      frame_valid_reg <= 1'b0;
      swap_done_reg   <= 1'b0;
      sof_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      front_reg       <= front_next;
      frame_valid_reg <= frame_valid_next;
      swap_done_reg   <= swap_done_next;
      sof_err_reg     <= sof_err_next;
    end
  end

  // Next-state logic: frame alignment, back-bank fill and swap handshake.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    front_next       = front_reg;
    frame_valid_next = frame_valid_reg;
    swap_done_next   = 1'b0;
    sof_err_next     = 1'b0;
    wr_en            = 1'b0;
    wr_pix           = cnt_reg;
    case (state_reg)
      SYNC: begin
        // Pixels before the first SOF carry no frame position; drop them.
        if (accept && bus.piul1WSof) begin
          wr_en      = 1'b1;
          wr_pix     = '0;
          cnt_next   = ONE;
          state_next = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (bus.piul1WSof) begin
            // Early SOF: restart the frame at pixel 0 and flag it.
            wr_pix       = '0;
            cnt_next     = ONE;
            sof_err_next = 1'b1;
          end else if (cnt_reg == LAST) begin
            cnt_next   = '0;
            state_next = FULL;
          end else begin
            cnt_next = cnt_reg + ONE;
          end
        end
      end
      FULL: begin
        // Swap wins over any pixel arriving in the same cycle.
        if (bus.piul1SwapReq) begin
          front_next       = ~front_reg;
          frame_valid_next = 1'b1;
          swap_done_next   = 1'b1;
          state_next       = SYNC;
        end
`ifdef FB_OVERWRITE_EN
        else if (accept && bus.piul1WSof) begin
          wr_en      = 1'b1;
          wr_pix     = '0;
          cnt_next   = ONE;
          state_next = FILL;
        end
`endif
      end
      default: state_next = SYNC;
    endcase
  end

  // Back-bank write port; array storage is left uninitialised.
  always_ff @(posedge piul1Clock) begin
    if (wr_en) begin
      mem[{~front_reg, wr_pix}] <= bus.piulWData;
    end
  end

  // Registered front-bank read; out-of-range addresses return zero.
  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= bus.piul1REnable;
      if (bus.piul1REnable) begin
        if ({1'b0, bus.piulRAddr} < NPIX_W) begin
          rdata_reg <= mem[{front_reg, bus.piulRAddr}];
        end else begin
          rdata_reg <= '0;
        end
      end
    end
  end

  assign bus.poul1WReady     = ready;
  assign bus.poulRData       = rdata_reg;
  assign bus.poul1RValid     = rvalid_reg;
  assign bus.poul1FrameValid = frame_valid_reg;
  assign bus.poul1SwapDone   = swap_done_reg;
  assign bus.poul1SofErr     = sof_err_reg;
endmodule
